interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

- Sits directly upstream of the CPU control FSM and drives its `interrupt` input.
- Synchronises the raw external interrupt lines, edge-detects them into per-line pending bits and applies a software mask.
- Presents one fixed-priority request, one-hot, and holds it stable through the FSM's two-cycle entry handshake.
- Tracks the in-service interrupt until the FSM's return-from-interrupt.

## Interface

- `INTERRUPT_WIDTH`, 4: number of interrupt lines; must match the FSM parameter.

- `clk` input 1: sole clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `irq_in` input INTERRUPT_WIDTH: raw external interrupt lines, asynchronous; a request is a rising edge.
- `mask_write` input 1: load `mask_data` into the mask register this cycle.
- `mask_data` input INTERRUPT_WIDTH: new mask; 1 = line enabled.
- `clear_write` input 1: clear pending bits selected by `clear_data` this cycle.
- `clear_data` input INTERRUPT_WIDTH: pending bits to clear.
- `save_state` input 1: FSM acknowledge pulse, high for one cycle during HANDLE_INTERRUPT_B.
- `restore_state` input 1: FSM return pulse, high for one cycle after RTI.
- `interrupt` output INTERRUPT_WIDTH: registered one-hot request to the FSM; 0 = none.
- `pending` output INTERRUPT_WIDTH: registered pending bits, for software readback.
- `mask` output INTERRUPT_WIDTH: current mask register.
- `in_service` output 1: an interrupt has been acknowledged and not yet returned.

## Operation

**Reset values (on `rst` at a clock edge)**
- `interrupt`=0, `pending`=0, `mask`=all ones, `in_service`=0, active register=0.
- Synchroniser flops and edge-history flops = 0.
- Reset mid-handshake or mid-service abandons the interrupt without restore. A line already high when `rst` deasserts counts as a rising edge.

**Synchronise and edge-detect (per line i)**
- Two-flop synchroniser `s0`→`s1`, then history flop `h`.
- `edge[i] = s1[i] & ~h[i]`.
- Level-high lines produce exactly one request.

**Pending update (per line i, each cycle)**
- Next `pending[i]` = `edge[i]`, OR (`pending[i]` AND NOT clear).
- Clear = `clear_write & clear_data[i]`, OR (`save_state` accepted AND `interrupt[i]`).
- Set wins over clear in the same cycle.

**Mask**
- `mask_write` updates `mask` at the next edge.
- Masking does not clear `pending`.

**Selection**
- `candidate = pending & mask`; the lowest index has highest priority.
- `select` = one-hot of the lowest set bit of `candidate`, or 0.

**Output register `interrupt`, priority order**
1. `rst`: becomes 0.
2. `in_service`=1: holds the active register value.
3. `interrupt`≠0 and no accepted `save_state`: holds its value (frozen). A presented request is never retracted or replaced, even by a mask write, a clear or a higher-priority arrival.
4. Otherwise: loads `select`.

**Acknowledge**
- `save_state` is accepted only when `interrupt`≠0 and `in_service`=0.
- On acceptance: active register ← `interrupt`, `in_service` ← 1, and that line's pending bit is cleared.
- `save_state` with `interrupt`=0 or `in_service`=1 is ignored; no state changes.

**Return**
- `restore_state` with `in_service`=1: `in_service` ← 0, active ← 0, and `interrupt` ← 0 at the same edge.
- Selection resumes on the following edge.
- `restore_state` with `in_service`=0 is ignored.
- `save_state` and `restore_state` in the same cycle: `restore_state` is applied, `save_state` is ignored.

## Timing

**Request latency**
- `irq_in[i]` rises before edge E0: `s0` at E0, `s1` at E1, `pending[i]` at E2, `interrupt` at E3, assuming the line is unmasked, not in service and nothing is frozen.
- The minimum request-to-output latency is therefore 4 rising edges.

**Handshake stability**
- `interrupt` holds constant from the cycle the FSM samples it in CHECK_INTERRUPT through the cycle `save_state` is high.
- The FSM computes its vector address from `interrupt` during the `save_state` cycle. That value equals what the block latches as active.

**Throughput and other latencies**
- A second edge on the same line while it is pending is absorbed; there is no counting.
- An edge while in service is recorded in `pending` and presented 1 edge after the return clears `interrupt`.
- `mask_write`/`clear_write` take effect on `mask`/`pending` one edge later. They affect `interrupt` only when it is not frozen, at the edge after that.

## Test plan

1. Reset then idle: after `rst`, all outputs 0 except `mask`=4'b1111. `irq_in`=0 for 10 cycles leaves `interrupt`=0.
2. Single request and latency: pulse `irq_in`=4'b0100 before E0. Require `pending`=4'b0100 at E2 and `interrupt`=4'b0100 at E3. Then `save_state` for 1 cycle: `in_service`=1, `pending`=0, `interrupt` stays 4'b0100. Then `restore_state`: `interrupt`=0 and `in_service`=0 next edge.
3. Priority and freeze: `irq_in`=4'b1000, then 4'b1001 after `interrupt`=4'b1000 appears. `interrupt` stays 4'b1000 until ack. After restore, `interrupt`=4'b0001 one edge after `interrupt` goes 0, and `pending`=4'b0001.
4. Masking: `mask_write` with 4'b1110, then raise line 0. Require `pending`=4'b0001 and `interrupt`=0. Then unmask: `interrupt`=4'b0001 two edges after `mask_write`.
5. Simultaneous set and ack: a new edge on line 2 lands in the same cycle `save_state` acks line 2. Require `pending[2]`=1 after that edge and the line re-presented after return.
6. Spurious and invalid pulses: `save_state` with `interrupt`=0, `restore_state` with `in_service`=0, and `rst` asserted while `in_service`=1. The first two cause no state change; `rst` returns all outputs to reset values at the next edge.

Source files
------------

// File: rtl/interrupt_controller.sv
// Interrupt front end for the CPU control FSM: synchronises and edge-detects the raw lines,
// keeps masked pending bits and presents one fixed-priority one-hot request through the handshake.
module interrupt_controller #(
    parameter int INTERRUPT_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [INTERRUPT_WIDTH-1:0] irq_in,
    input  logic                       mask_write,
    input  logic [INTERRUPT_WIDTH-1:0] mask_data,
    input  logic                       clear_write,
    input  logic [INTERRUPT_WIDTH-1:0] clear_data,
    input  logic                       save_state,
    input  logic                       restore_state,
    output logic [INTERRUPT_WIDTH-1:0] interrupt,
    output logic [INTERRUPT_WIDTH-1:0] pending,
    output logic [INTERRUPT_WIDTH-1:0] mask,
    output logic                       in_service
);

    typedef logic [INTERRUPT_WIDTH-1:0] vec_t;

    vec_t s0_q, s0_d;
    vec_t s1_q, s1_d;
    vec_t h_q, h_d;
    vec_t pending_q, pending_d;
    vec_t mask_q, mask_d;
    vec_t interrupt_q, interrupt_d;
    vec_t active_q, active_d;
    logic in_service_q, in_service_d;

    vec_t irq_edge;
    vec_t clear_sel;
    vec_t candidate;
    vec_t select;
    logic save_accept;
    logic restore_accept;

    // NOTE: every variable assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        restore_accept = restore_state & in_service_q;
        save_accept    = save_state & ~restore_state & ~in_service_q & (interrupt_q != '0);

        irq_edge  = s1_q & ~h_q;
        clear_sel = (clear_write ? clear_data : '0) | (save_accept ? interrupt_q : '0);

        candidate = pending_q & mask_q;
        // Isolate the lowest set bit: lowest index wins.
        select    = candidate & (~candidate + vec_t'(1));
    end

    always_comb begin
        s0_d         = irq_in;
        s1_d         = s0_q;
        h_d          = s1_q;
        pending_d    = irq_edge | (pending_q & ~clear_sel);
        mask_d       = mask_write ? mask_data : mask_q;
        interrupt_d  = select;
        active_d     = active_q;
        in_service_d = in_service_q;

        if (restore_accept) begin
            interrupt_d  = '0;
            active_d     = '0;
            in_service_d = 1'b0;
        end else if (in_service_q) begin
            interrupt_d = active_q;
        end else if (interrupt_q != '0) begin
            // A presented request stays frozen; on acceptance it becomes the active one.
            interrupt_d = interrupt_q;
            if (save_accept) begin
                active_d     = interrupt_q;
                in_service_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q         <= '0;
            s1_q         <= '0;
            h_q          <= '0;
            pending_q    <= '0;
            mask_q       <= '1;
            interrupt_q  <= '0;
            active_q     <= '0;
            in_service_q <= 1'b0;
        end else begin
            s0_q         <= s0_d;
            s1_q         <= s1_d;
            h_q          <= h_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            interrupt_q  <= interrupt_d;
            active_q     <= active_d;
            in_service_q <= in_service_d;
        end
    end

    assign interrupt  = interrupt_q;
    assign pending    = pending_q;
    assign mask       = mask_q;
    assign in_service = in_service_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios followed by a randomized run, all checked
// cycle by cycle against a line-indexed behavioural model.
module tb_interrupt_controller;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] irq_in;
    logic         mask_write;
    logic [W-1:0] mask_data;
    logic         clear_write;
    logic [W-1:0] clear_data;
    logic         save_state;
    logic         restore_state;
    logic [W-1:0] interrupt;
    logic [W-1:0] pending;
    logic [W-1:0] mask;
    logic         in_service;

    always #5 clk = ~clk;

    interrupt_controller #(.INTERRUPT_WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .irq_in        (irq_in),
        .mask_write    (mask_write),
        .mask_data     (mask_data),
        .clear_write   (clear_write),
        .clear_data    (clear_data),
        .save_state    (save_state),
        .restore_state (restore_state),
        .interrupt     (interrupt),
        .pending       (pending),
        .mask          (mask),
        .in_service    (in_service)
    );

    int n_vectors     = 0;
    int n_miscompares = 0;

    // Reference model: lines are tracked by index; -1 means no line.
    logic [W-1:0] m_samples [$];   // past irq_in samples, newest first
    bit           m_pending [W];
    bit           m_enabled [W];
    int           m_req;
    int           m_active;
    bit           m_in_service;

    task automatic model_reset();
        m_samples = {};
        for (int k = 0; k < 3; k++) m_samples.push_back('0);
        for (int i = 0; i < W; i++) begin
            m_pending[i] = 1'b0;
            m_enabled[i] = 1'b1;
        end
        m_req        = -1;
        m_active     = -1;
        m_in_service = 1'b0;
    endtask

    task automatic model_step();
        bit new_pend [W];
        int lowest;
        bit save_ok;
        bit restore_ok;
        bit rose;
        if (rst) begin
            model_reset();
            return;
        end
        lowest = -1;
        for (int i = W - 1; i >= 0; i--)
            if (m_pending[i] && m_enabled[i]) lowest = i;
        save_ok    = save_state && !restore_state && m_req >= 0 && !m_in_service;
        restore_ok = restore_state && m_in_service;
        for (int i = 0; i < W; i++) begin
            rose = m_samples[1][i] && !m_samples[2][i];
            if (rose) new_pend[i] = 1'b1;
            else if ((clear_write && clear_data[i]) || (save_ok && m_req == i)) new_pend[i] = 1'b0;
            else new_pend[i] = m_pending[i];
        end
        if (restore_ok) begin
            m_req        = -1;
            m_active     = -1;
            m_in_service = 1'b0;
        end else if (save_ok) begin
            m_active     = m_req;
            m_in_service = 1'b1;
        end else if (m_req < 0) begin
            m_req = lowest;
        end
        m_pending = new_pend;
        if (mask_write)
            for (int i = 0; i < W; i++) m_enabled[i] = mask_data[i];
        m_samples.push_front(irq_in);
        void'(m_samples.pop_back());
    endtask

    function automatic logic [W-1:0] exp_interrupt();
        logic [W-1:0] v = '0;
        if (m_req >= 0) v[m_req] = 1'b1;
        return v;
    endfunction

    function automatic logic [W-1:0] exp_pending();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = m_pending[i];
        return v;
    endfunction

    function automatic logic [W-1:0] exp_mask();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = m_enabled[i];
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vectors++;
        assert (observed === expected) else begin
            n_miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("model_interrupt", 32'(interrupt), 32'(exp_interrupt()));
        check("model_pending", 32'(pending), 32'(exp_pending()));
        check("model_mask", 32'(mask), 32'(exp_mask()));
        check("model_in_service", 32'(in_service), 32'(m_in_service));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic pulse_save();
        save_state = 1'b1;
        tick();
        save_state = 1'b0;
    endtask

    task automatic pulse_restore();
        restore_state = 1'b1;
        tick();
        restore_state = 1'b0;
    endtask

    initial begin
        int idx;
        rst = 1'b1; irq_in = '0; mask_write = 1'b0; mask_data = '0;
        clear_write = 1'b0; clear_data = '0; save_state = 1'b0; restore_state = 1'b0;
        model_reset();

        // Reset then idle
        tick();
        check("t1_interrupt", 32'(interrupt), 32'h0);
        check("t1_pending", 32'(pending), 32'h0);
        check("t1_mask", 32'(mask), 32'hf);
        check("t1_in_service", 32'(in_service), 32'h0);
        rst = 1'b0;
        ticks(10);
        check("t1_idle_interrupt", 32'(interrupt), 32'h0);

        // Single request, latency, ack and return
        irq_in = 4'b0100;
        tick();                                   // E0
        irq_in = '0;
        tick();                                   // E1
        check("t2_pending_E1", 32'(pending), 32'h0);
        tick();                                   // E2
        check("t2_pending_E2", 32'(pending), 32'h4);
        check("t2_interrupt_E2", 32'(interrupt), 32'h0);
        tick();                                   // E3
        check("t2_interrupt_E3", 32'(interrupt), 32'h4);
        pulse_save();
        check("t2_ack_in_service", 32'(in_service), 32'h1);
        check("t2_ack_pending", 32'(pending), 32'h0);
        check("t2_ack_interrupt", 32'(interrupt), 32'h4);
        ticks(2);
        pulse_restore();
        check("t2_ret_interrupt", 32'(interrupt), 32'h0);
        check("t2_ret_in_service", 32'(in_service), 32'h0);
        ticks(3);

        // Priority and freeze
        irq_in = 4'b1000;
        ticks(4);
        check("t3_first", 32'(interrupt), 32'h8);
        irq_in = 4'b1001;
        ticks(4);
        check("t3_frozen", 32'(interrupt), 32'h8);
        check("t3_pending_both", 32'(pending), 32'h9);
        pulse_save();
        check("t3_ack_interrupt", 32'(interrupt), 32'h8);
        pulse_restore();
        check("t3_ret_interrupt", 32'(interrupt), 32'h0);
        tick();
        check("t3_next_interrupt", 32'(interrupt), 32'h1);
        check("t3_next_pending", 32'(pending), 32'h1);
        pulse_save();
        pulse_restore();
        irq_in = '0;
        ticks(4);

        // Masking
        mask_write = 1'b1; mask_data = 4'b1110;
        tick();
        mask_write = 1'b0;
        check("t4_mask", 32'(mask), 32'he);
        irq_in = 4'b0001;
        ticks(3);
        check("t4_pending", 32'(pending), 32'h1);
        tick();
        check("t4_masked_interrupt", 32'(interrupt), 32'h0);
        mask_write = 1'b1; mask_data = 4'b1111;
        tick();
        mask_write = 1'b0;
        check("t4_unmask_edge1", 32'(interrupt), 32'h0);
        tick();
        check("t4_unmask_edge2", 32'(interrupt), 32'h1);
        pulse_save();
        pulse_restore();
        irq_in = '0;
        ticks(4);

        // New edge on line 2 lands at the same edge that acks line 2
        irq_in = 4'b0100;
        tick();                                   // E0
        irq_in = '0;
        ticks(3);                                 // E1..E3
        check("t5_present", 32'(interrupt), 32'h4);
        irq_in = 4'b0100;
        ticks(2);                                 // F0, F1
        pulse_save();                             // F2
        check("t5_pending_kept", 32'(pending), 32'h4);
        check("t5_in_service", 32'(in_service), 32'h1);
        pulse_restore();
        check("t5_ret_interrupt", 32'(interrupt), 32'h0);
        tick();
        check("t5_represent", 32'(interrupt), 32'h4);
        pulse_save();
        pulse_restore();
        irq_in = '0;
        ticks(4);

        // Spurious pulses, then reset mid-service
        pulse_save();
        check("t6_spur_save_in_service", 32'(in_service), 32'h0);
        check("t6_spur_save_interrupt", 32'(interrupt), 32'h0);
        pulse_restore();
        check("t6_spur_restore_in_service", 32'(in_service), 32'h0);
        check("t6_spur_restore_pending", 32'(pending), 32'h0);
        mask_write = 1'b1; mask_data = 4'b0111;
        tick();
        mask_write = 1'b0;
        irq_in = 4'b0010;
        ticks(4);
        check("t6_present", 32'(interrupt), 32'h2);
        pulse_save();
        check("t6_in_service", 32'(in_service), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_interrupt", 32'(interrupt), 32'h0);
        check("t6_rst_pending", 32'(pending), 32'h0);
        check("t6_rst_mask", 32'(mask), 32'hf);
        check("t6_rst_in_service", 32'(in_service), 32'h0);
        ticks(3);
        check("t6_high_after_rst", 32'(pending), 32'h2);
        tick();
        pulse_save();
        pulse_restore();

        // Randomized traffic with an FSM-like acknowledger
        repeat (3000) begin
            save_state = 1'b0; restore_state = 1'b0;
            mask_write = 1'b0; clear_write = 1'b0; rst = 1'b0;
            if ($urandom_range(0, 5) == 0) begin
                idx = $urandom_range(0, W - 1);
                irq_in[idx] = ~irq_in[idx];
            end
            if ($urandom_range(0, 31) == 0) begin
                mask_write = 1'b1;
                mask_data  = W'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 31) == 0) begin
                clear_write = 1'b1;
                clear_data  = W'($urandom_range(0, 15));
            end
            if (m_in_service) begin
                if ($urandom_range(0, 5) == 0) restore_state = 1'b1;
            end else if (m_req >= 0) begin
                if ($urandom_range(0, 2) == 0) save_state = 1'b1;
            end
            if (!save_state && !restore_state && $urandom_range(0, 47) == 0) begin
                if ($urandom_range(0, 1) == 0) save_state = 1'b1;
                else restore_state = 1'b1;
            end
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
